// File: rtl/alu_share_arbiter_pkg.sv
// Shared opcode encodings and control-state names for the shared ALU arbiter.
package alu_share_arbiter_pkg;

   localparam int unsigned OPW = 3;

   typedef enum logic [OPW-1:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_XOR = 3'b010,
      OP_NOR = 3'b011,
      OP_ADD = 3'b100,
      OP_SUB = 3'b101,
      OP_SLL = 3'b110,
      OP_SRL = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      EMPTY         = 2'd0,
      FULL_DRAINING = 2'd1,
      FULL_STALLED  = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational logic/arithmetic unit shared by all requesters.
module alu_logic_unit
   import alu_share_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OPW-1:0]   op,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (alu_op_e'(op))
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NOR:  y = ~(a | b);
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_SLL:  y = a << b[4:0];
         OP_SRL:  y = a >> b[4:0];
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters, with a
// one-deep id-tagged result buffer and a saturating stall counter.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*OPW-1:0]   req_op,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [WIDTH-1:0]      resp_data,
   output logic [IDW-1:0]        resp_id,
   output logic [15:0]           busy_cnt
);

   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   gnt_idx;
   logic [IDW-1:0]   nxt_ptr;
   logic [IDW:0]     scan_pos;
   logic             gnt_any;
   logic             can_accept;
   logic             xfer;
   ctrl_state_e      ctrl_st;
   logic [WIDTH-1:0] a_sel;
   logic [WIDTH-1:0] b_sel;
   logic [OPW-1:0]   op_sel;
   logic [WIDTH-1:0] alu_y;

   // The only stored control bit is resp_valid; the drain/stall split
   // depends on resp_ready in the current cycle.
   always_comb begin
      ctrl_st = EMPTY;
      if (resp_valid) ctrl_st = resp_ready ? FULL_DRAINING : FULL_STALLED;
      can_accept = (ctrl_st != FULL_STALLED);
   end

   // Scan from rr_ptr upward, wrapping at NREQ (which need not be a power of two).
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_pos = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_pos = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (scan_pos >= (IDW+1)'(NREQ)) scan_pos = scan_pos - (IDW+1)'(NREQ);
         if (!gnt_any && req_valid[scan_pos[IDW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_pos[IDW-1:0];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (rst && can_accept && gnt_any) req_ready[gnt_idx] = 1'b1;
      xfer = |req_ready;
   end

   always_comb begin
      a_sel  = '0;
      b_sel  = '0;
      op_sel = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (gnt_idx == IDW'(k)) begin
            a_sel  = req_a[k*WIDTH +: WIDTH];
            b_sel  = req_b[k*WIDTH +: WIDTH];
            op_sel = req_op[k*OPW +: OPW];
         end
      end
      nxt_ptr = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
   end

   alu_logic_unit #(.WIDTH(WIDTH)) u_alu (
      .a  (a_sel),
      .b  (b_sel),
      .op (op_sel),
      .y  (alu_y)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_id    <= '0;
         busy_cnt   <= '0;
         rr_ptr     <= '0;
      end else begin
         if (xfer) begin
            resp_valid <= 1'b1;
            resp_data  <= alu_y;
            resp_id    <= gnt_idx;
            rr_ptr     <= nxt_ptr;
         end else if (ctrl_st == FULL_DRAINING) begin
            resp_valid <= 1'b0;
         end
         if (|req_valid && !can_accept && busy_cnt != '1) busy_cnt <= busy_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: grants, results, backpressure, fairness, reset.
module tb_alu_share_arbiter;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  id;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic [11:0]  req_op;
   logic         resp_valid;
   logic         resp_ready;
   logic [31:0]  resp_data;
   logic [1:0]   resp_id;
   logic [15:0]  busy_cnt;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   m_rr   = 0;
   int   m_busy = 0;

   alu_share_arbiter #(.WIDTH(32), .NREQ(4), .IDW(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_id    (resp_id),
      .busy_cnt   (busy_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] model_op(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
      logic [4:0] sh;
      sh = b[4:0];
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a | b);
         3'd4:    return a + b;
         3'd5:    return a - b;
         3'd6:    return a << sh;
         default: return a >> sh;
      endcase
   endfunction

   function automatic int pick(input logic [3:0] v, input int rr);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (rr + k) % 4;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op);
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      req_op[i*3 +: 3]  = op;
      req_valid[i]      = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 32'd1, 32'd2, 3'b100);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b expected 0", resp_valid);
      end
      checks++;
      if (resp_data !== 32'd0) begin
         errors++; $display("FAIL reset_data: got %h expected 0", resp_data);
      end
      checks++;
      if (resp_id !== 2'd0) begin
         errors++; $display("FAIL reset_id: got %0d expected 0", resp_id);
      end
      checks++;
      if (busy_cnt !== 16'd0) begin
         errors++; $display("FAIL reset_busy: got %0d expected 0", busy_cnt);
      end
      rst = 1'b1;
      req_valid = '0;
      m_rr = 0;
      m_busy = 0;
   endtask

   task automatic test_all_four();
      exp_t e;
      for (int i = 0; i < 4; i++) set_req(i, 32'd1000245, 32'd134422, 3'b100);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 4'(1 << k)) begin
            errors++; $display("FAIL all4_grant%0d: got %b expected %b", k, req_ready, 4'(1 << k));
         end
         sb.push_back('{data: model_op(32'd1000245, 32'd134422, 3'b100), id: 2'(k)});
         @(posedge clk); #1;
         req_valid[k] = 1'b0;
         m_rr = (k + 1) % 4;
         e = sb.pop_front();
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== e.data || resp_id !== e.id) begin
            errors++;
            $display("FAIL all4_resp%0d: got v=%b d=%0d id=%0d expected v=1 d=%0d id=%0d",
                     k, resp_valid, resp_data, resp_id, e.data, e.id);
         end
      end
   endtask

   task automatic test_single();
      exp_t e;
      set_req(0, 32'd1000000007, 32'd143, 3'b010);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++; $display("FAIL single_grant: got %b expected 0001", req_ready);
      end
      sb.push_back('{data: model_op(32'd1000000007, 32'd143, 3'b010), id: 2'd0});
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      m_rr = 1;
      e = sb.pop_front();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== e.data || resp_id !== e.id) begin
         errors++;
         $display("FAIL single_resp: got v=%b d=%0d id=%0d expected v=1 d=%0d id=%0d",
                  resp_valid, resp_data, resp_id, e.data, e.id);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++; $display("FAIL single_drain: got %b expected 0", resp_valid);
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      exp_t held;
      int   g;
      set_req(0, 32'h1234_5678, 32'h0F0F_0F0F, 3'b000);
      g = pick(req_valid, m_rr);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'(1 << g)) begin
         errors++; $display("FAIL bp_first_grant: got %b expected %b", req_ready, 4'(1 << g));
      end
      sb.push_back('{data: model_op(32'h1234_5678, 32'h0F0F_0F0F, 3'b000), id: 2'(g)});
      @(posedge clk); #1;
      req_valid[g] = 1'b0;
      m_rr = (g + 1) % 4;
      held = sb.pop_front();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== held.data || resp_id !== held.id) begin
         errors++;
         $display("FAIL bp_first_resp: got v=%b d=%h id=%0d expected v=1 d=%h id=%0d",
                  resp_valid, resp_data, resp_id, held.data, held.id);
      end
      resp_ready = 1'b0;
      set_req(2, 32'd7, 32'd9, 3'b101);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_stall_ready%0d: got %b expected 0000", c, req_ready);
         end
         @(posedge clk); #1;
         m_busy++;
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== held.data || resp_id !== held.id) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b d=%h id=%0d expected v=1 d=%h id=%0d",
                     c, resp_valid, resp_data, resp_id, held.data, held.id);
         end
      end
      checks++;
      if (busy_cnt !== 16'(m_busy)) begin
         errors++; $display("FAIL bp_busy: got %0d expected %0d", busy_cnt, m_busy);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL bp_release_grant: got %b expected 0100", req_ready);
      end
      sb.push_back('{data: model_op(32'd7, 32'd9, 3'b101), id: 2'd2});
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      m_rr = 3;
      e = sb.pop_front();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== e.data || resp_id !== e.id) begin
         errors++;
         $display("FAIL bp_release_resp: got v=%b d=%h id=%0d expected v=1 d=%h id=%0d",
                  resp_valid, resp_data, resp_id, e.data, e.id);
      end
      checks++;
      if (busy_cnt !== 16'(m_busy)) begin
         errors++; $display("FAIL bp_busy_after: got %0d expected %0d", busy_cnt, m_busy);
      end
   endtask

   task automatic test_shifts();
      logic [31:0] ta[3];
      logic [31:0] tb[3];
      logic [2:0]  top[3];
      logic [31:0] texp[3];
      exp_t        e;
      int          g;
      ta[0] = 32'h8000_0001; tb[0] = 32'd33; top[0] = 3'b110; texp[0] = 32'h0000_0002;
      ta[1] = 32'h0000_0000; tb[1] = 32'd1;  top[1] = 3'b101; texp[1] = 32'hFFFF_FFFF;
      ta[2] = 32'hF000_0000; tb[2] = 32'd4;  top[2] = 3'b111; texp[2] = 32'h0F00_0000;
      for (int j = 0; j < 3; j++) begin
         set_req(0, ta[j], tb[j], top[j]);
         g = pick(req_valid, m_rr);
         @(negedge clk);
         checks++;
         if (req_ready !== 4'(1 << g)) begin
            errors++; $display("FAIL shift_grant%0d: got %b expected %b", j, req_ready, 4'(1 << g));
         end
         sb.push_back('{data: texp[j], id: 2'(g)});
         @(posedge clk); #1;
         req_valid[g] = 1'b0;
         m_rr = (g + 1) % 4;
         e = sb.pop_front();
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== e.data || resp_id !== e.id) begin
            errors++;
            $display("FAIL shift_resp%0d: got v=%b d=%h id=%0d expected v=1 d=%h id=%0d",
                     j, resp_valid, resp_data, resp_id, e.data, e.id);
         end
      end
   endtask

   task automatic test_fairness();
      exp_t e;
      int   exp_id;
      set_req(3, 32'hA5A5_0000, 32'h0000_5A5A, 3'b011);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++; $display("FAIL fair_seed_grant: got %b expected 1000", req_ready);
      end
      sb.push_back('{data: model_op(32'hA5A5_0000, 32'h0000_5A5A, 3'b011), id: 2'd3});
      @(posedge clk); #1;
      m_rr = 0;
      e = sb.pop_front();
      checks++;
      if (resp_data !== e.data || resp_id !== e.id) begin
         errors++; $display("FAIL fair_seed_resp: got d=%h id=%0d expected d=%h id=%0d",
                            resp_data, resp_id, e.data, e.id);
      end
      set_req(1, 32'h0000_00F0, 32'h0000_000F, 3'b001);
      for (int k = 0; k < 6; k++) begin
         exp_id = (k % 2 == 0) ? 1 : 3;
         @(negedge clk);
         checks++;
         if (req_ready !== 4'(1 << exp_id)) begin
            errors++; $display("FAIL fair_grant%0d: got %b expected %b", k, req_ready, 4'(1 << exp_id));
         end
         if (exp_id == 1) sb.push_back('{data: model_op(32'h0000_00F0, 32'h0000_000F, 3'b001), id: 2'd1});
         else             sb.push_back('{data: model_op(32'hA5A5_0000, 32'h0000_5A5A, 3'b011), id: 2'd3});
         @(posedge clk); #1;
         m_rr = (exp_id + 1) % 4;
         e = sb.pop_front();
         checks++;
         if (resp_valid !== 1'b1 || resp_data !== e.data || resp_id !== e.id) begin
            errors++;
            $display("FAIL fair_resp%0d: got v=%b d=%h id=%0d expected v=1 d=%h id=%0d",
                     k, resp_valid, resp_data, resp_id, e.data, e.id);
         end
      end
      req_valid = '0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_stall();
      exp_t e;
      set_req(2, 32'd100, 32'd23, 3'b100);
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++; $display("FAIL rst_pre_grant: got %b expected 0100", req_ready);
      end
      sb.push_back('{data: model_op(32'd100, 32'd23, 3'b100), id: 2'd2});
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      m_rr = 3;
      e = sb.pop_front();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== e.data || resp_id !== e.id) begin
         errors++; $display("FAIL rst_pre_resp: got v=%b d=%0d id=%0d expected v=1 d=%0d id=%0d",
                            resp_valid, resp_data, resp_id, e.data, e.id);
      end
      resp_ready = 1'b0;
      set_req(1, 32'd5, 32'd6, 3'b100);
      set_req(3, 32'd8, 32'd9, 3'b100);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         m_busy++;
      end
      checks++;
      if (busy_cnt !== 16'(m_busy)) begin
         errors++; $display("FAIL rst_pre_busy: got %0d expected %0d", busy_cnt, m_busy);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++; $display("FAIL rst_mid_ready: got %b expected 0000", req_ready);
      end
      @(posedge clk); #1;
      m_rr = 0;
      m_busy = 0;
      checks++;
      if (resp_valid !== 1'b0 || resp_data !== 32'd0 || resp_id !== 2'd0 || busy_cnt !== 16'(m_busy)) begin
         errors++; $display("FAIL rst_mid_state: got v=%b d=%h id=%0d busy=%0d expected v=0 d=0 id=0 busy=0",
                            resp_valid, resp_data, resp_id, busy_cnt);
      end
      rst = 1'b1;
      resp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++; $display("FAIL rst_post_grant: got %b expected 0010", req_ready);
      end
      sb.push_back('{data: model_op(32'd5, 32'd6, 3'b100), id: 2'd1});
      @(posedge clk); #1;
      req_valid = '0;
      m_rr = 2;
      e = sb.pop_front();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== e.data || resp_id !== e.id) begin
         errors++; $display("FAIL rst_post_resp: got v=%b d=%0d id=%0d expected v=1 d=%0d id=%0d",
                            resp_valid, resp_data, resp_id, e.data, e.id);
      end
   endtask

   initial begin
      rst        = 1'b0;
      resp_ready = 1'b1;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_op     = '0;
      @(posedge clk); #1;
      test_reset();
      test_all_four();
      test_single();
      test_backpressure();
      test_shifts();
      test_fairness();
      test_reset_mid_stall();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
